// File: rtl/dwrite_burst_pkg.sv
// Shared types and sizing helpers for the dwrite_burst SDRAM write path.
package dwrite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int addr_step(input int dw);
    return dw / 8;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dwrite_burst_if.sv
// Sample-source and sdramc write-port bundle; master is the burst writer, slave its environment.
interface dwrite_burst_if #(
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int DEPTH = 512
);
  localparam int LW = dwrite_pkg::level_w(DEPTH);

  logic          sample_en;
  logic [31:0]   sample_last_cnt;
  logic          capture_done;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          wr_req;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_done;
  logic          wfifo_full;
  logic [LW-1:0] wfifo_level;
  logic          wfifo_ovf;

  modport master (
    input  sample_en, sample_last_cnt, capture_done, din, din_valid, wr_valid,
    output din_ready, wr_req, wr_addr, wr_data, wr_done, wfifo_full, wfifo_level, wfifo_ovf
  );

  modport slave (
    output sample_en, sample_last_cnt, capture_done, din, din_valid, wr_valid,
    input  din_ready, wr_req, wr_addr, wr_data, wr_done, wfifo_full, wfifo_level, wfifo_ovf
  );
endinterface

// File: rtl/dwrite_burst_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with synchronous clear, full/empty flags and level.
module sync_fifo
  import dwrite_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [DW-1:0]             wdata_i,
  output logic [DW-1:0]             rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [level_w(DEPTH)-1:0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + PW'(1);
      if (do_pop)  rp_q <= rp_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/dwrite_burst.sv
// Burst writer: buffers a sample stream and drains it to sdramc in fixed-length bursts over a ring.
// Optional DWRITE_PAD_EN: flush bursts are padded to BURST_LEN beats with zero data.
module dwrite_burst
  import dwrite_pkg::*;
#(
  parameter int DW        = 16,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 8,
  parameter int AW        = 32
) (
  input  logic           sdram_clk,
  input  logic           sdram_rst,
  dwrite_burst_if.master bus
);
  localparam int              LW   = level_w(DEPTH);
  localparam int              CW   = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]   BL   = CW'(BURST_LEN);
  localparam logic [AW-1:0]   STEP = AW'(addr_step(DW));

  state_e        state_q, state_d;
  logic          en_q, en_prev_q;
  logic          wr_req_q, wr_req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   idx_q, idx_d;
  logic          ovf_q, ovf_d;

  logic          rise, fall, push, pop, beat, din_ready_w;
  logic          fifo_clr, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] flush_len;

  assign rise        = en_q && !en_prev_q;
  assign fall        = !en_q && en_prev_q;
  assign din_ready_w = (state_q == ST_RUN) && !fifo_full;
  assign push        = bus.din_valid && din_ready_w;
  assign beat        = wr_req_q && bus.wr_valid;
  assign pop         = beat && !fifo_empty;

`ifdef DWRITE_PAD_EN
  assign flush_len = BL;
`else
  assign flush_len = (fifo_level >= LW'(BURST_LEN)) ? BL : CW'(fifo_level);
`endif

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (sdram_clk),
    .rst_i   (sdram_rst),
    .clr_i   (fifo_clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.din),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    wr_req_d = wr_req_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    fifo_clr = 1'b0;

    if (beat) begin
      cnt_d = cnt_q - CW'(1);
      idx_d = (idx_q == bus.sample_last_cnt) ? 32'd0 : idx_q + 32'd1;
      if (cnt_q == CW'(1)) wr_req_d = 1'b0;
    end
    if (state_q == ST_RUN && bus.din_valid && fifo_full) ovf_d = 1'b1;

    unique case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (!wr_req_q && fifo_level >= LW'(BURST_LEN)) begin
          wr_req_d = 1'b1;
          cnt_d    = BL;
        end
        if (bus.capture_done) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!wr_req_q) begin
          if (fifo_empty) begin
            state_d = ST_DONE;
          end else begin
            wr_req_d = 1'b1;
            cnt_d    = flush_len;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort drops the burst mid-flight; a new session start overrides everything.
    if (fall && (state_q == ST_RUN || state_q == ST_FLUSH)) begin
      state_d  = ST_IDLE;
      wr_req_d = 1'b0;
      cnt_d    = '0;
      fifo_clr = 1'b1;
    end
    if (rise) begin
      state_d  = ST_RUN;
      wr_req_d = 1'b0;
      cnt_d    = '0;
      idx_d    = '0;
      ovf_d    = 1'b0;
      fifo_clr = 1'b1;
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      en_prev_q <= 1'b0;
      wr_req_q  <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= bus.sample_en;
      en_prev_q <= en_q;
      wr_req_q  <= wr_req_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.din_ready   = din_ready_w;
  assign bus.wr_req      = wr_req_q;
  assign bus.wr_addr     = AW'(idx_q) * STEP;
  assign bus.wr_data     = (wr_req_q && !fifo_empty) ? fifo_head : '0;
  assign bus.wr_done     = (state_q == ST_DONE);
  assign bus.wfifo_full  = fifo_full;
  assign bus.wfifo_level = fifo_level;
  assign bus.wfifo_ovf   = ovf_q;
endmodule

// File: tb/tb_dwrite_burst.sv
// Directed/randomized bench for dwrite_burst against a queue-based reference of the write stream.
module tb_dwrite_burst;
  localparam int DW    = 16;
  localparam int DEPTH = 512;
  localparam int BL    = 8;
  localparam int AW    = 32;
`ifdef DWRITE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dwrite_burst_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

  dwrite_burst #(.DW(DW), .DEPTH(DEPTH), .BURST_LEN(BL), .AW(AW)) dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .bus       (bus)
  );

  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] model_q[$];
  int            bursts[$];
  int            cur_len, sess_beats, sess_pushes, done_cnt, cyc_n, push8_cyc, first_req_cyc;
  logic          prev_req, rand_wv;
  logic [31:0]   last_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already set; observe at the falling edge, return just after the rising edge.
  task automatic cyc();
    longint exp_a;
    logic [DW-1:0] exp_d;
    if (rand_wv) bus.wr_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("level", 64'(bus.wfifo_level), 64'(model_q.size()));
    if (bus.wr_req && bus.wr_valid) begin
      exp_a = (longint'(sess_beats) % (longint'(last_cnt) + 1)) * (DW / 8);
      exp_d = (model_q.size() > 0) ? model_q.pop_front() : '0;
      chk("wr_data", 64'(bus.wr_data), 64'(exp_d));
      chk("wr_addr", 64'(bus.wr_addr), 64'(exp_a));
      sess_beats++;
    end
    if (bus.din_valid && bus.din_ready) begin
      model_q.push_back(bus.din);
      sess_pushes++;
      if (sess_pushes == BL) push8_cyc = cyc_n;
    end
    if (bus.wr_req && first_req_cyc < 0) first_req_cyc = cyc_n;
    if (bus.wr_req) begin
      if (!prev_req) cur_len = 0;
      if (bus.wr_valid) cur_len++;
    end else if (prev_req) begin
      bursts.push_back(cur_len);
    end
    prev_req = bus.wr_req;
    if (bus.wr_done) done_cnt++;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [31:0] last);
    bus.sample_en    = 1'b0;
    bus.din_valid    = 1'b0;
    bus.capture_done = 1'b0;
    cyc();
    cyc();
    last_cnt            = last;
    bus.sample_last_cnt = last;
    model_q.delete();
    bursts.delete();
    sess_beats    = 0;
    sess_pushes   = 0;
    done_cnt      = 0;
    first_req_cyc = -1;
    push8_cyc     = -1;
    bus.sample_en = 1'b1;
    for (int i = 0; i < 8 && !bus.din_ready; i++) cyc();
    chk("session_run", 64'(bus.din_ready), 64'd1);
  endtask

  task automatic push_words(input int n);
    int target;
    target = sess_pushes + n;
    for (int i = 0; i < n * 4 + 50 && sess_pushes < target; i++) begin
      bus.din       = DW'($urandom);
      bus.din_valid = 1'b1;
      cyc();
    end
    bus.din_valid = 1'b0;
    chk("push_count", 64'(sess_pushes), 64'(target));
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !bus.wr_req; i++) cyc();
    chk("req_seen", 64'(bus.wr_req), 64'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && !(model_q.size() == 0 && !prev_req); i++) cyc();
    chk({tag, "_drained"}, 64'(model_q.size() == 0 && !prev_req), 64'd1);
  endtask

  task automatic flush_and_done(input string tag);
    bus.capture_done = 1'b1;
    cyc();
    bus.capture_done = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) cyc();
    for (int i = 0; i < 4; i++) cyc();
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_din_ready"}, 64'(bus.din_ready), 64'd0);
    chk({tag, "_wr_req"},    64'(bus.wr_req),    64'd0);
    chk({tag, "_wr_addr"},   64'(bus.wr_addr),   64'd0);
    chk({tag, "_wr_data"},   64'(bus.wr_data),   64'd0);
    chk({tag, "_wr_done"},   64'(bus.wr_done),   64'd0);
    chk({tag, "_full"},      64'(bus.wfifo_full), 64'd0);
    chk({tag, "_level"},     64'(bus.wfifo_level), 64'd0);
    chk({tag, "_ovf"},       64'(bus.wfifo_ovf), 64'd0);
  endtask

  initial begin
    bus.sample_en       = 1'b0;
    bus.sample_last_cnt = '0;
    bus.capture_done    = 1'b0;
    bus.din             = '0;
    bus.din_valid       = 1'b0;
    bus.wr_valid        = 1'b0;
    last_cnt = '0;
    prev_req = 1'b0;
    rand_wv  = 1'b0;
    cur_len = 0; sess_beats = 0; sess_pushes = 0; done_cnt = 0; cyc_n = 0;
    push8_cyc = -1; first_req_cyc = -1;

    // Reset values
    #1 rst = 1'b1;
    #1 chk_outputs_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Steady stream: 32 words, sdramc always ready, no wrap
    start_session(32'd1000);
    bus.wr_valid = 1'b1;
    push_words(32);
    wait_drain("steady", 200);
    chk("steady_latency", 64'(first_req_cyc - push8_cyc), 64'd2);
    chk("steady_nbursts", 64'(bursts.size()), 64'd4);
    foreach (bursts[i]) chk("steady_burst_len", 64'(bursts[i]), 64'(BL));
    chk("steady_beats", 64'(sess_beats), 64'd32);
    chk("steady_last_addr", 64'(bus.wr_addr), 64'h40);
    flush_and_done("steady");

    // Wrap at index 5 with random sdramc stalls
    start_session(32'd5);
    rand_wv = 1'b1;
    push_words(12);
    flush_and_done("wrap");
    rand_wv = 1'b0;
    bus.wr_valid = 1'b1;
    chk("wrap_nbursts", 64'(bursts.size()), 64'd2);
    if (bursts.size() == 2) begin
      chk("wrap_burst0", 64'(bursts[0]), 64'(BL));
      chk("wrap_burst1", 64'(bursts[1]), PAD ? 64'(BL) : 64'd4);
    end
    chk("wrap_beats", 64'(sess_beats), PAD ? 64'd16 : 64'd12);

    // Flush: 11 words then capture_done
    start_session(32'd1000);
    bus.wr_valid = 1'b1;
    push_words(11);
    flush_and_done("flush");
    chk("flush_nbursts", 64'(bursts.size()), 64'd2);
    if (bursts.size() == 2) begin
      chk("flush_burst0", 64'(bursts[0]), 64'(BL));
      chk("flush_burst1", 64'(bursts[1]), PAD ? 64'(BL) : 64'd3);
    end
    chk("flush_beats", 64'(sess_beats), PAD ? 64'd16 : 64'd11);

    // Back-pressure: sdramc stalled, DEPTH+4 words offered
    start_session(32'd1000);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      bus.din       = DW'($urandom);
      bus.din_valid = 1'b1;
      cyc();
    end
    bus.din_valid = 1'b0;
    chk("bp_level", 64'(bus.wfifo_level), 64'(DEPTH));
    chk("bp_full", 64'(bus.wfifo_full), 64'd1);
    chk("bp_din_ready", 64'(bus.din_ready), 64'd0);
    chk("bp_ovf", 64'(bus.wfifo_ovf), 64'd1);
    chk("bp_accepted", 64'(sess_pushes), 64'(DEPTH));
    bus.wr_valid = 1'b1;
    wait_drain("bp", 1200);
    chk("bp_nbursts", 64'(bursts.size()), 64'(DEPTH / BL));
    chk("bp_ovf_sticky", 64'(bus.wfifo_ovf), 64'd1);
    flush_and_done("bp");
    chk("bp_ovf_after_done", 64'(bus.wfifo_ovf), 64'd1);

    // Abort mid-burst after 3 beats
    start_session(32'd1000);
    chk("abort_ovf_cleared", 64'(bus.wfifo_ovf), 64'd0);
    bus.wr_valid = 1'b0;
    push_words(8);
    wait_req();
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 20 && sess_beats < 3; i++) cyc();
    bus.wr_valid  = 1'b0;
    bus.sample_en = 1'b0;
    chk("abort_beats", 64'(sess_beats), 64'd3);
    cyc();
    cyc();
    chk("abort_wr_req", 64'(bus.wr_req), 64'd0);
    chk("abort_level", 64'(bus.wfifo_level), 64'd0);
    chk("abort_din_ready", 64'(bus.din_ready), 64'd0);
    model_q.delete();
    for (int i = 0; i < 6; i++) cyc();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    start_session(32'd1000);
    bus.wr_valid = 1'b0;
    push_words(8);
    wait_req();
    chk("restart_addr", 64'(bus.wr_addr), 64'd0);
    bus.wr_valid = 1'b1;
    wait_drain("restart", 100);
    chk("restart_beats", 64'(sess_beats), 64'(BL));
    flush_and_done("restart");

    // Asynchronous reset in the middle of a burst
    start_session(32'd1000);
    bus.wr_valid = 1'b0;
    push_words(8);
    wait_req();
    bus.wr_valid = 1'b1;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1 chk_outputs_zero("arst");
    bus.sample_en = 1'b0;
    bus.wr_valid  = 1'b0;
    @(posedge clk); #1;
    model_q.delete();
    prev_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("arst_idle", 64'(bus.din_ready), 64'd0);
    chk("arst_no_req", 64'(bus.wr_req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
